// File: rtl/seq_table_ctrl.sv
// Double-buffered sequencer table loader: packs 32-bit table words into 128-bit
// frames in the write bank, then swaps banks once the sequencer is idle.
module seq_table_ctrl #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          TABLE_START,
  input  logic [31:0]   TABLE_DATA,
  input  logic          TABLE_WSTB,
  input  logic [15:0]   TABLE_LENGTH,
  input  logic          TABLE_LENGTH_WSTB,
  input  logic          seq_active_i,
  output logic          mem_wr_o,
  output logic [AW:0]   mem_addr_o,
  output logic [127:0]  mem_data_o,
  output logic          rd_bank_o,
  output logic [AW:0]   table_frames_o,
  output logic          table_ready_o,
  output logic          swap_o,
  output logic          load_err_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, LOADING, PENDING} state_t;

  typedef struct packed {
    logic          wr;
    logic [AW:0]   addr;
    logic [127:0]  data;
  } frame_wr_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][31:0] words_q, words_d;
  logic [AW:0]     fcnt_q, fcnt_d;
  frame_wr_t       fw_q, fw_d;
  logic            rd_bank_q, rd_bank_d;
  logic [AW:0]     frames_q, frames_d;
  logic            ready_q, ready_d;
  logic            swap_q, swap_d;
  logic            err_q, err_d;

  // Index/count after any coincident word, so the length check sees it.
  logic [1:0]      idx_n;
  logic [AW:0]     fcnt_n;
  logic            ovf;
  logic [31:0]     len4, len_in;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      words_q   <= '0;
      fcnt_q    <= '0;
      fw_q      <= '0;
      rd_bank_q <= 1'b0;
      frames_q  <= '0;
      ready_q   <= 1'b0;
      swap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      words_q   <= words_d;
      fcnt_q    <= fcnt_d;
      fw_q      <= fw_d;
      rd_bank_q <= rd_bank_d;
      frames_q  <= frames_d;
      ready_q   <= ready_d;
      swap_q    <= swap_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    words_d   = words_q;
    fcnt_d    = fcnt_q;
    fw_d      = fw_q;
    fw_d.wr   = 1'b0;
    rd_bank_d = rd_bank_q;
    frames_d  = frames_q;
    ready_d   = ready_q;
    swap_d    = 1'b0;
    err_d     = err_q;
    idx_n     = idx_q;
    fcnt_n    = fcnt_q;
    ovf       = 1'b0;
    len4      = '0;
    len_in    = 32'(TABLE_LENGTH);

    if (TABLE_START) begin
      idx_d   = '0;
      fcnt_d  = '0;
      err_d   = 1'b0;
      state_d = LOADING;
    end else begin
      case (state_q)
        LOADING: begin
          if (TABLE_WSTB) begin
            words_d[idx_q] = TABLE_DATA;
            idx_n = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              // fcnt MSB set means the bank is already full
              if (fcnt_q[AW]) begin
                ovf = 1'b1;
              end else begin
                fw_d.wr   = 1'b1;
                fw_d.addr = {~rd_bank_q, fcnt_q[AW-1:0]};
                fw_d.data = {TABLE_DATA, words_q[2], words_q[1], words_q[0]};
                fcnt_n    = fcnt_q + (AW+1)'(1);
              end
            end
          end
          idx_d  = idx_n;
          fcnt_d = fcnt_n;
          len4   = 32'({fcnt_n, 2'b00});
          if (ovf) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (TABLE_LENGTH_WSTB) begin
            if (idx_n == 2'd0 && fcnt_n != '0 && len_in == len4) begin
              state_d = PENDING;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        PENDING: begin
          if (TABLE_WSTB || TABLE_LENGTH_WSTB) err_d = 1'b1;
          if (!seq_active_i) begin
            rd_bank_d = ~rd_bank_q;
            frames_d  = fcnt_q;
            ready_d   = 1'b1;
            swap_d    = 1'b1;
            state_d   = IDLE;
          end
        end
        default: begin
          if (TABLE_WSTB || TABLE_LENGTH_WSTB) err_d = 1'b1;
        end
      endcase
    end
  end

  assign mem_wr_o       = fw_q.wr;
  assign mem_addr_o     = fw_q.addr;
  assign mem_data_o     = fw_q.data;
  assign rd_bank_o      = rd_bank_q;
  assign table_frames_o = frames_q;
  assign table_ready_o  = ready_q;
  assign swap_o         = swap_q;
  assign load_err_o     = err_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_seq_table_ctrl.sv
// Random + directed bench for seq_table_ctrl against a word-queue reference model.
module tb_seq_table_ctrl;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, start, wstb, lstb, act;
  logic [31:0]   data;
  logic [15:0]   len;
  logic          mem_wr_o, rd_bank_o, table_ready_o, swap_o, load_err_o, busy_o;
  logic [AW:0]   mem_addr_o, table_frames_o;
  logic [127:0]  mem_data_o;

  seq_table_ctrl #(.AW(AW)) dut (
    .clk_i(clk), .reset_i(rst), .TABLE_START(start), .TABLE_DATA(data),
    .TABLE_WSTB(wstb), .TABLE_LENGTH(len), .TABLE_LENGTH_WSTB(lstb),
    .seq_active_i(act), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .rd_bank_o(rd_bank_o), .table_frames_o(table_frames_o),
    .table_ready_o(table_ready_o), .swap_o(swap_o), .load_err_o(load_err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, wr_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the whole current load is kept as a queue of words.
  bit          m_load, m_pend, m_bank, m_ready, m_err, m_wr, m_swap;
  int          m_frames;
  logic [AW:0] m_addr;
  logic [127:0] m_data;
  int unsigned wq[$];

  task automatic model_step();
    m_wr = 0; m_swap = 0;
    if (rst) begin
      m_load = 0; m_pend = 0; m_bank = 0; m_ready = 0; m_err = 0;
      m_frames = 0; m_addr = '0; m_data = '0; wq.delete();
    end else if (start) begin
      wq.delete(); m_load = 1; m_pend = 0; m_err = 0;
    end else if (m_load) begin
      if (wstb) begin
        wq.push_back(data);
        if (wq.size() % 4 == 0) begin
          int n;
          n = wq.size() / 4 - 1;
          if (n >= (1 << AW)) begin
            m_err = 1; m_load = 0;
          end else begin
            m_wr = 1;
            m_addr = {~m_bank, n[AW-1:0]};
            m_data = {wq[n*4+3], wq[n*4+2], wq[n*4+1], wq[n*4]};
          end
        end
      end
      if (m_load && lstb) begin
        m_load = 0;
        if (wq.size() > 0 && wq.size() % 4 == 0 && int'(len) == wq.size()) m_pend = 1;
        else m_err = 1;
      end
    end else if (m_pend) begin
      if (wstb || lstb) m_err = 1;
      if (!act) begin
        m_bank = ~m_bank; m_frames = wq.size() / 4; m_ready = 1; m_swap = 1; m_pend = 0;
      end
    end else begin
      if (wstb || lstb) m_err = 1;
    end
  endtask

  task automatic compare();
    if (mem_wr_o === 1'b1) wr_cnt++;
    chk("mem_wr", mem_wr_o, m_wr);
    if (m_wr) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_data", mem_data_o, m_data);
    end
    chk("swap", swap_o, m_swap);
    chk("rd_bank", rd_bank_o, m_bank);
    chk("frames", table_frames_o, m_frames);
    chk("ready", table_ready_o, m_ready);
    chk("load_err", load_err_o, m_err);
    chk("busy", busy_o, m_load | m_pend);
  endtask

  // One clock: inputs already set; model follows the edge, outputs sampled at negedge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    start = 0; wstb = 0; lstb = 0;
  endtask

  task automatic words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      data = base + i; wstb = 1; cyc();
    end
  endtask

  initial begin
    rst = 1; start = 0; wstb = 0; lstb = 0; act = 0; data = '0; len = '0;
    cyc(); cyc();
    chk("rst_wr", mem_wr_o, 0); chk("rst_addr", mem_addr_o, 0); chk("rst_data", mem_data_o, 0);
    chk("rst_bank", rd_bank_o, 0); chk("rst_frames", table_frames_o, 0);
    chk("rst_ready", table_ready_o, 0); chk("rst_swap", swap_o, 0);
    chk("rst_err", load_err_o, 0); chk("rst_busy", busy_o, 0);
    rst = 0;

    // Basic load: words 1..8, length on the last word
    start = 1; cyc();
    for (int i = 1; i <= 8; i++) begin
      data = i; wstb = 1;
      if (i == 8) begin lstb = 1; len = 8; end
      cyc();
      if (i == 4) begin
        chk("basic_wr0", mem_wr_o, 1);
        chk("basic_addr0", mem_addr_o, 3'b100);
        chk("basic_data0", mem_data_o, {32'd4, 32'd3, 32'd2, 32'd1});
      end
    end
    chk("basic_wr1", mem_wr_o, 1);
    chk("basic_addr1", mem_addr_o, 3'b101);
    chk("basic_data1", mem_data_o, {32'd8, 32'd7, 32'd6, 32'd5});
    chk("basic_noswap_yet", swap_o, 0);
    cyc();
    chk("basic_swap", swap_o, 1);
    chk("basic_bank", rd_bank_o, 1);
    chk("basic_frames", table_frames_o, 2);
    chk("basic_ready", table_ready_o, 1);

    // Deferred swap while sequencer busy
    act = 1; start = 1; cyc();
    words(7, 1); data = 8; wstb = 1; lstb = 1; len = 8; cyc();
    for (int i = 0; i < 50; i++) cyc();
    chk("defer_bank_held", rd_bank_o, 1);
    act = 0; cyc();
    chk("defer_swap", swap_o, 1);
    chk("defer_bank", rd_bank_o, 0);

    // Length mismatch leaves active table alone
    start = 1; cyc();
    words(6, 32'h100); lstb = 1; len = 8; cyc();
    chk("mism_err", load_err_o, 1);
    chk("mism_busy", busy_o, 0);
    chk("mism_bank", rd_bank_o, 0);
    chk("mism_frames", table_frames_o, 2);

    // Abort and reload one frame
    start = 1; cyc(); words(4, 32'h200);
    start = 1; cyc(); words(3, 32'h300);
    data = 32'h303; wstb = 1; lstb = 1; len = 4; cyc();
    chk("abort_addr", mem_addr_o, 3'b100);
    cyc();
    chk("abort_frames", table_frames_o, 1);

    // Overflow: 20 words into a 4-frame bank
    wr_cnt = 0;
    start = 1; cyc(); words(20, 32'h400);
    chk("ovf_writes", wr_cnt, 4);
    chk("ovf_err", load_err_o, 1);
    chk("ovf_busy", busy_o, 0);

    // Reset mid-load
    start = 1; cyc(); words(3, 32'h500);
    rst = 1; cyc(); rst = 0;
    chk("mid_rst_bank", rd_bank_o, 0); chk("mid_rst_frames", table_frames_o, 0);
    chk("mid_rst_busy", busy_o, 0); chk("mid_rst_wr", mem_wr_o, 0);
    wr_cnt = 0;
    words(5, 32'h600);
    chk("mid_rst_nowr", wr_cnt, 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom % 700 == 0);
      start = ($urandom % 40 == 0);
      wstb  = ($urandom % 3 != 0);
      data  = $urandom;
      lstb  = ($urandom % 8 == 0);
      len   = ($urandom % 2 == 0) ? 16'(wq.size() + int'(wstb)) : 16'($urandom % 24);
      if ($urandom % 15 == 0) act = ~act;
      cyc();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
